char_display_grid: RTL and testbench

- Parametrised text-overlay stage for the VGA timing pipeline; successor of the fixed 16x3 character overlay.
- Draws a COLS x ROWS grid of 8x16 glyphs at (X_POS, Y_POS), each glyph pixel replicated 2^SCALE_LOG2 times in both axes.
- Drives a synchronous font/char ROM (1-cycle read latency) via char_xy/char_line and merges returned glyph bits into rgb.
- Adds frame-based blink, enable gating, an optional opaque background, and a fixed 2-cycle aligned pipeline for all timing signals.

---
 rtl/char_display_grid.sv | 210 +++++++++++++++++++++
 tb/tb_char_display_grid.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_display_grid.sv
// char_display_grid: COLS x ROWS text overlay with scaling, blink and an
// opaque-background option, aligned to a fixed 2-cycle timing pipeline.
//
// Ports:
//   pclk, rst                      pixel clock, async active-high reset
//   en, blink_en                   overlay / blink enables (pixel-aligned)
//   hcount_in..vblnk_in, rgb_in    upstream timing and colour
//   char_xy, char_line             ROM address {row,col} and glyph line
//   char_pixels                    ROM data, 1 cycle after the address
//   hcount_out..vblnk_out, rgb_out timing and merged colour, 2 cycles late
module char_display_grid #(
    parameter int          X_POS        = 0,
    parameter int          Y_POS        = 0,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 3,
    parameter int          COL_W        = 4,
    parameter int          ROW_W        = 4,
    parameter int          SCALE_LOG2   = 0,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BG_OPAQUE    = 0,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     blink_en,
    input  logic [10:0]              hcount_in,
    input  logic [10:0]              vcount_in,
    input  logic                     hsync_in,
    input  logic                     hblnk_in,
    input  logic                     vsync_in,
    input  logic                     vblnk_in,
    input  logic [11:0]              rgb_in,
    input  logic [7:0]               char_pixels,
    output logic [ROW_W+COL_W-1:0]   char_xy,
    output logic [3:0]               char_line,
    output logic [10:0]              hcount_out,
    output logic [10:0]              vcount_out,
    output logic                     hsync_out,
    output logic                     hblnk_out,
    output logic                     vsync_out,
    output logic                     vblnk_out,
    output logic [11:0]              rgb_out
);

    localparam int RECT_W = (COLS * 8) << SCALE_LOG2;
    localparam int RECT_H = (ROWS * 16) << SCALE_LOG2;
    localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam int unsigned X_LO = X_POS;
    localparam int unsigned X_HI = X_POS + RECT_W;
    localparam int unsigned Y_LO = Y_POS;
    localparam int unsigned Y_HI = Y_POS + RECT_H;
    localparam logic [10:0] X11  = 11'(X_POS);
    localparam logic [10:0] Y11  = 11'(Y_POS);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // geometry
    logic              in_rect;
    logic [10:0]       hrel, vrel, x, y;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              unused_bits;

    // stage 1
    logic              s1_in_rect_d, s1_in_rect_q;
    logic [2:0]        s1_bitsel_d, s1_bitsel_q;
    logic              s1_en_d, s1_en_q;
    logic              s1_blink_en_d, s1_blink_en_q;
    logic [11:0]       s1_rgb_d, s1_rgb_q;
    logic [10:0]       s1_hcount_d, s1_hcount_q;
    logic [10:0]       s1_vcount_d, s1_vcount_q;
    logic              s1_hsync_d, s1_hsync_q;
    logic              s1_hblnk_d, s1_hblnk_q;
    logic              s1_vsync_d, s1_vsync_q;
    logic              s1_vblnk_d, s1_vblnk_q;

    // stage 2 / outputs
    logic [10:0]       hcount_out_d, hcount_out_q;
    logic [10:0]       vcount_out_d, vcount_out_q;
    logic              hsync_out_d, hsync_out_q;
    logic              hblnk_out_d, hblnk_out_q;
    logic              vsync_out_d, vsync_out_q;
    logic              vblnk_out_d, vblnk_out_q;
    logic [11:0]       rgb_out_d, rgb_out_q;

    // blink
    logic [FW-1:0]     frame_d, frame_q;
    logic              blink_phase_d, blink_phase_q;
    logic              glyph_bit;

    always_comb begin
        in_rect = (32'(hcount_in) >= X_LO) && (32'(hcount_in) < X_HI) &&
                  (32'(vcount_in) >= Y_LO) && (32'(vcount_in) < Y_HI);
        // wraps below X_POS/Y_POS; in_rect masks those pixels
        hrel = hcount_in - X11;
        vrel = vcount_in - Y11;
        x    = hrel >> SCALE_LOG2;
        y    = vrel >> SCALE_LOG2;
        col  = x[COL_W+2:3];
        row  = y[ROW_W+3:4];
        char_xy   = '0;
        char_line = '0;
        if (in_rect) begin
            char_xy   = {row, col};
            char_line = y[3:0];
        end
    end

    assign unused_bits = ^{x[10:COL_W+3], y[10:ROW_W+4]};

    always_comb begin
        s1_in_rect_d  = in_rect;
        s1_bitsel_d   = x[2:0];
        s1_en_d       = en;
        s1_blink_en_d = blink_en;
        s1_rgb_d      = rgb_in;
        s1_hcount_d   = hcount_in;
        s1_vcount_d   = vcount_in;
        s1_hsync_d    = hsync_in;
        s1_hblnk_d    = hblnk_in;
        s1_vsync_d    = vsync_in;
        s1_vblnk_d    = vblnk_in;

        hcount_out_d  = s1_hcount_q;
        vcount_out_d  = s1_vcount_q;
        hsync_out_d   = s1_hsync_q;
        hblnk_out_d   = s1_hblnk_q;
        vsync_out_d   = s1_vsync_q;
        vblnk_out_d   = s1_vblnk_q;

        // s1_vsync_q doubles as the previous-vsync sample for edge detect
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        if (vsync_in && !s1_vsync_q) begin
            if (frame_q == FRAME_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        glyph_bit = char_pixels[3'd7 - s1_bitsel_q];
        rgb_out_d = s1_rgb_q;
        if (s1_en_q && s1_in_rect_q) begin
            if (glyph_bit && !(s1_blink_en_q && blink_phase_q)) begin
                rgb_out_d = FG_COLOR;
            end else if (BG_OPAQUE != 0) begin
                rgb_out_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_in_rect_q  <= 1'b0;
            s1_bitsel_q   <= '0;
            s1_en_q       <= 1'b0;
            s1_blink_en_q <= 1'b0;
            s1_rgb_q      <= '0;
            s1_hcount_q   <= '0;
            s1_vcount_q   <= '0;
            s1_hsync_q    <= 1'b0;
            s1_hblnk_q    <= 1'b0;
            s1_vsync_q    <= 1'b0;
            s1_vblnk_q    <= 1'b0;
            hcount_out_q  <= '0;
            vcount_out_q  <= '0;
            hsync_out_q   <= 1'b0;
            hblnk_out_q   <= 1'b0;
            vsync_out_q   <= 1'b0;
            vblnk_out_q   <= 1'b0;
            rgb_out_q     <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            s1_in_rect_q  <= s1_in_rect_d;
            s1_bitsel_q   <= s1_bitsel_d;
            s1_en_q       <= s1_en_d;
            s1_blink_en_q <= s1_blink_en_d;
            s1_rgb_q      <= s1_rgb_d;
            s1_hcount_q   <= s1_hcount_d;
            s1_vcount_q   <= s1_vcount_d;
            s1_hsync_q    <= s1_hsync_d;
            s1_hblnk_q    <= s1_hblnk_d;
            s1_vsync_q    <= s1_vsync_d;
            s1_vblnk_q    <= s1_vblnk_d;
            hcount_out_q  <= hcount_out_d;
            vcount_out_q  <= vcount_out_d;
            hsync_out_q   <= hsync_out_d;
            hblnk_out_q   <= hblnk_out_d;
            vsync_out_q   <= vsync_out_d;
            vblnk_out_q   <= vblnk_out_d;
            rgb_out_q     <= rgb_out_d;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign hcount_out = hcount_out_q;
    assign vcount_out = vcount_out_q;
    assign hsync_out  = hsync_out_q;
    assign hblnk_out  = hblnk_out_q;
    assign vsync_out  = vsync_out_q;
    assign vblnk_out  = vblnk_out_q;
    assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_char_display_grid.sv
// tb_char_display_grid: two overlay instances (unscaled/transparent and
// scaled/opaque) on shared random stimulus, checked against a pixel model.
module tb_char_display_grid;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        en = 1'b0, blink_en = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0;
    logic        vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;

    logic [7:0]  pix_a = '0, pix_b = '0;
    logic [7:0]  xy_a, xy_b;
    logic [3:0]  line_a, line_b;
    logic [10:0] ho_a, vo_a, ho_b, vo_b;
    logic        hs_a, hb_a, vs_a, vb_a, hs_b, hb_b, vs_b, vb_b;
    logic [11:0] rgb_a, rgb_b;

    localparam logic [11:0] FG_B = 12'h5f0;
    localparam logic [11:0] BG_B = 12'h0a5;

    int n_vec = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    char_display_grid #(
        .X_POS(100), .Y_POS(50), .SCALE_LOG2(0),
        .BG_OPAQUE(0), .BLINK_FRAMES(2)
    ) dut_a (
        .pclk(pclk), .rst(rst), .en(en), .blink_en(blink_en),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(pix_a),
        .char_xy(xy_a), .char_line(line_a),
        .hcount_out(ho_a), .vcount_out(vo_a),
        .hsync_out(hs_a), .hblnk_out(hb_a),
        .vsync_out(vs_a), .vblnk_out(vb_a),
        .rgb_out(rgb_a)
    );

    char_display_grid #(
        .X_POS(0), .Y_POS(0), .SCALE_LOG2(1),
        .FG_COLOR(FG_B), .BG_COLOR(BG_B),
        .BG_OPAQUE(1), .BLINK_FRAMES(2)
    ) dut_b (
        .pclk(pclk), .rst(rst), .en(en), .blink_en(blink_en),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(pix_b),
        .char_xy(xy_b), .char_line(line_b),
        .hcount_out(ho_b), .vcount_out(vo_b),
        .hsync_out(hs_b), .hblnk_out(hb_b),
        .vsync_out(vs_b), .vblnk_out(vb_b),
        .rgb_out(rgb_b)
    );

    function automatic logic [7:0] rom_f(input int xy, input int ln);
        if (xy == 'h12 && ln == 3) return 8'b1000_0001;
        return 8'((xy * 29 + ln * 7 + 3) ^ (ln << 4));
    endfunction

    // synchronous font ROM, one cycle of latency
    always @(posedge pclk) begin
        pix_a <= rom_f(int'(xy_a), int'(line_a));
        pix_b <= rom_f(int'(xy_b), int'(line_b));
    end

    typedef struct {
        logic [10:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] ra, rb;
    } exp_t;

    exp_t e1, e2, zero_e;
    int   edges   = 0;
    bit   prev_vs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // where a pixel falls in a text rectangle of 16x3 cells
    task automatic geom(input int x0, y0, s, h, v, output bit inr,
                        output int xy, output int ln, output int bs);
        int px, py;
        inr = (h >= x0) && (h < x0 + (128 << s)) &&
              (v >= y0) && (v < y0 + (48 << s));
        xy = 0; ln = 0; bs = 0;
        if (inr) begin
            px = (h - x0) >> s;
            py = (v - y0) >> s;
            xy = (py / 16) * 16 + px / 8;
            ln = py % 16;
            bs = px % 8;
        end
    endtask

    function automatic logic [11:0] pix_rgb(
        input bit inr, input int xy, ln, bs, input bit e, be, ph,
        input logic [11:0] fg, bg, input bit opaque, input logic [11:0] rgb);
        logic [7:0] g;
        g = rom_f(xy, ln);
        if (!e || !inr) return rgb;
        if (g[7 - bs] && !(be && ph)) return fg;
        if (opaque) return bg;
        return rgb;
    endfunction

    task automatic cyc(input int h, v, input bit e, be, vs, r);
        exp_t n;
        bit   inr;
        int   xy, ln, bs;
        bit   ph;
        @(negedge pclk);
        chk("hcount_a", 32'(ho_a), 32'(e2.h));
        chk("vcount_a", 32'(vo_a), 32'(e2.v));
        chk("hsync_a",  32'(hs_a), 32'(e2.hs));
        chk("hblnk_a",  32'(hb_a), 32'(e2.hb));
        chk("vsync_a",  32'(vs_a), 32'(e2.vs));
        chk("vblnk_a",  32'(vb_a), 32'(e2.vb));
        chk("rgb_a",    32'(rgb_a), 32'(e2.ra));
        chk("hcount_b", 32'(ho_b), 32'(e2.h));
        chk("vsync_b",  32'(vs_b), 32'(e2.vs));
        chk("rgb_b",    32'(rgb_b), 32'(e2.rb));
        rst       = r;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        en        = e;
        blink_en  = be;
        vsync_in  = vs;
        hsync_in  = 1'($urandom);
        hblnk_in  = 1'($urandom);
        vblnk_in  = 1'($urandom);
        rgb_in    = 12'($urandom);
        #1;
        n = zero_e;
        if (r) begin
            edges   = 0;
            prev_vs = 1'b0;
        end else begin
            if (vs && !prev_vs) edges++;
            prev_vs = vs;
        end
        ph = ((edges / 2) % 2) == 1;
        geom(100, 50, 0, h, v, inr, xy, ln, bs);
        chk("char_xy_a",   32'(xy_a),   32'(xy));
        chk("char_line_a", 32'(line_a), 32'(ln));
        n.ra = pix_rgb(inr, xy, ln, bs, e, be, ph,
                       12'hfff, 12'h000, 1'b0, rgb_in);
        geom(0, 0, 1, h, v, inr, xy, ln, bs);
        chk("char_xy_b",   32'(xy_b),   32'(xy));
        chk("char_line_b", 32'(line_b), 32'(ln));
        n.rb = pix_rgb(inr, xy, ln, bs, e, be, ph, FG_B, BG_B, 1'b1, rgb_in);
        n.h  = 11'(h);
        n.v  = 11'(v);
        n.hs = hsync_in;
        n.hb = hblnk_in;
        n.vs = vs;
        n.vb = vblnk_in;
        if (r) begin
            e1 = zero_e;
            e2 = zero_e;
        end else begin
            e2 = e1;
            e1 = n;
        end
    endtask

    initial begin
        bit vsr;
        zero_e = '{h: '0, v: '0, hs: 0, hb: 0, vs: 0, vb: 0, ra: '0, rb: '0};
        e1 = zero_e;
        e2 = zero_e;

        for (int i = 0; i < 4; i++)
            cyc($urandom_range(0, 400), $urandom_range(0, 200),
                1, 1, 1'($urandom), 1);
        cyc(5, 0, 1, 0, 0, 0);
        cyc(6, 0, 1, 0, 0, 0);

        // placement, edges, scaled mapping
        cyc(116, 69, 1, 0, 0, 0);
        cyc(117, 69, 1, 0, 0, 0);
        cyc(123, 69, 1, 0, 0, 0);
        cyc(227, 60, 1, 0, 0, 0);
        cyc(228, 60, 1, 0, 0, 0);
        cyc(116, 97, 1, 0, 0, 0);
        cyc(116, 98, 1, 0, 0, 0);
        cyc(99,  60, 1, 0, 0, 0);
        cyc(100, 49, 1, 0, 0, 0);
        cyc(0,   0,  1, 0, 0, 0);
        cyc(1,   0,  1, 0, 0, 0);
        cyc(16,  0,  1, 0, 0, 0);
        cyc(5,   31, 1, 0, 0, 0);
        cyc(5,   32, 1, 0, 0, 0);
        cyc(255, 95, 1, 0, 0, 0);
        cyc(256, 95, 1, 0, 0, 0);
        cyc(5,   96, 1, 0, 0, 0);

        // blink: vsync pulses while parked on lit glyph pixels
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) cyc(116, 69, 1, 1, 0, 0);
            for (int i = 0; i < 3; i++) cyc(123, 69, 1, 1, 1, 0);
            cyc(0, 0, 1, 1, 1, 0);
        end

        // enable off
        for (int i = 0; i < 40; i++)
            cyc($urandom_range(90, 240), $urandom_range(40, 110),
                0, 1'($urandom), 0, 0);

        // mid-line reset after some blink activity
        for (int i = 0; i < 6; i++) cyc(116, 69, 1, 1, i % 2, 0);
        cyc(118, 69, 1, 1, 0, 1);
        cyc(119, 69, 1, 1, 0, 1);
        for (int i = 0; i < 6; i++) cyc(116 + i * 7, 69, 1, 1, 0, 0);

        // random traffic with slow vsync
        vsr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) vsr = ~vsr;
            cyc($urandom_range(0, 300), $urandom_range(0, 120),
                $urandom_range(0, 7) != 0, 1'($urandom), vsr,
                $urandom_range(0, 499) == 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
